// File: rtl/sbus_uart_rx.sv
// S-Bus serial byte receiver: 8 data bits LSB first, even parity, 2 stop bits,
// optionally inverted line. Feeds the S-Bus frame decoder.
module sbus_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1000,
  parameter bit          INVERT       = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rdy_o,
  output logic       err_o
);

  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF - 1);
  localparam logic          IDLE_RAW  = !INVERT;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_IDLE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            ln, ln_q, fall, tick;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic            stop1_q, stop1_d;
  logic [7:0]      data_d;
  logic            rdy_d, err_d;

  // Synchronized, polarity-corrected line; edge detect runs in every state
  assign ln   = sync_q[1] ^ INVERT;
  assign fall = ln_q & ~ln;
  assign tick = (timer_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= {2{IDLE_RAW}};
      ln_q      <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      stop1_q   <= 1'b0;
      data_o    <= '0;
      rdy_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      ln_q      <= ln;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      stop1_q   <= stop1_d;
      data_o    <= data_d;
      rdy_o     <= rdy_d;
      err_o     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = tick ? '0 : timer_q - TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    stop1_d   = stop1_q;
    data_d    = data_o;
    rdy_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          timer_d = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (!ln) begin
            state_d   = DATA;
            timer_d   = BIT_LOAD;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {ln, shift_q[7:1]};
          timer_d   = BIT_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick) begin
          par_ok_d = ~^{shift_q, ln};
          timer_d  = BIT_LOAD;
          state_d  = STOP1;
        end
      end
      STOP1: begin
        if (tick) begin
          stop1_d = ln;
          timer_d = BIT_LOAD;
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (tick) begin
          if (stop1_q && ln) begin
            if (par_ok_q) begin
              rdy_d  = 1'b1;
              data_d = shift_q;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            // Break or framing error: one error, then wait for idle line
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (ln) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sbus_uart_rx.sv
// Directed bench for sbus_uart_rx at 16 clocks/bit with an inverted line.
module tb_sbus_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned LAT  = 2 + HALF + 11 * CPB + 1;
  localparam bit          INV  = 1'b1;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_i = INV ? 1'b0 : 1'b1;
  logic [7:0] data_o;
  logic       rdy_o, err_o;

  int vectors = 0;
  int errors  = 0;

  int          cyc = 0;
  int          rdy_cnt = 0, err_cnt = 0, both_cnt = 0;
  int          rdy_cyc = -1, err_cyc = -1;
  logic [7:0]  exp_data = 8'h00;

  sbus_uart_rx #(.CLKS_PER_BIT(CPB), .INVERT(INV)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rx_i  (rx_i),
    .data_o(data_o),
    .rdy_o (rdy_o),
    .err_o (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rdy_o) begin rdy_cnt++; rdy_cyc = cyc; end
    if (err_o) begin err_cnt++; err_cyc = cyc; end
    if (rdy_o && err_o) both_cnt++;
  end

  // Tasks enter and leave on a falling clock edge.
  task automatic drive_bit(input logic b);
    rx_i = b ^ INV;
    repeat (CPB) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, output int e);
    e = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s1);
    drive_bit(s2);
  endtask

  task automatic check_good(input string name, input logic [7:0] d, input logic p);
    int e, r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(d, p, 1'b1, 1'b1, e);
    repeat (4) @(negedge clk_i);
    vectors++;
    if (rdy_cnt !== r0 + 1) begin
      errors++; $display("FAIL %s rdy count: got %0d want %0d", name, rdy_cnt - r0, 1);
    end
    vectors++;
    if (rdy_cyc !== e + LAT) begin
      errors++; $display("FAIL %s rdy cycle: got %0d want %0d", name, rdy_cyc, e + LAT);
    end
    vectors++;
    if (data_o !== d) begin
      errors++; $display("FAIL %s data: got %02h want %02h", name, data_o, d);
    end
    vectors++;
    if (err_cnt !== e0) begin
      errors++; $display("FAIL %s err count: got %0d want 0", name, err_cnt - e0);
    end
    exp_data = d;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    vectors++;
    if ({data_o, rdy_o, err_o} !== 10'h000) begin
      errors++; $display("FAIL reset outputs: got %02h/%b/%b want 00/0/0", data_o, rdy_o, err_o);
    end
    rst_ni = 1'b1;
    repeat (20) @(negedge clk_i);
    vectors++;
    if (rdy_cnt + err_cnt !== 0) begin
      errors++; $display("FAIL reset release pulses: got %0d want 0", rdy_cnt + err_cnt);
    end
  endtask

  task automatic test_valid;
    check_good("valid_f0", 8'hF0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int e1, e2, r0;
    r0 = rdy_cnt;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, e1);
    vectors++;
    if (data_o !== 8'h01) begin
      errors++; $display("FAIL b2b first data: got %02h want 01", data_o);
    end
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, e2);
    repeat (4) @(negedge clk_i);
    vectors++;
    if (rdy_cnt !== r0 + 2) begin
      errors++; $display("FAIL b2b rdy count: got %0d want 2", rdy_cnt - r0);
    end
    vectors++;
    if (rdy_cyc !== e1 + 12 * CPB + LAT) begin
      errors++; $display("FAIL b2b second rdy cycle: got %0d want %0d", rdy_cyc, e1 + 12 * CPB + LAT);
    end
    vectors++;
    if (data_o !== 8'h00) begin
      errors++; $display("FAIL b2b second data: got %02h want 00", data_o);
    end
    exp_data = 8'h00;
  endtask

  task automatic test_parity_error;
    int e, r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 1'b1, e);
    repeat (4) @(negedge clk_i);
    vectors++;
    if (err_cnt !== e0 + 1) begin
      errors++; $display("FAIL parity err count: got %0d want 1", err_cnt - e0);
    end
    vectors++;
    if (err_cyc !== e + LAT) begin
      errors++; $display("FAIL parity err cycle: got %0d want %0d", err_cyc, e + LAT);
    end
    vectors++;
    if (rdy_cnt !== r0) begin
      errors++; $display("FAIL parity rdy count: got %0d want 0", rdy_cnt - r0);
    end
    vectors++;
    if (data_o !== exp_data) begin
      errors++; $display("FAIL parity data held: got %02h want %02h", data_o, exp_data);
    end
  endtask

  task automatic test_break;
    int e, r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    e = cyc;
    // Start, 0x00, parity 0, then low through both stops and 50 more bits
    repeat (12 + 50) drive_bit(1'b0);
    vectors++;
    if (err_cnt !== e0 + 1) begin
      errors++; $display("FAIL break err count: got %0d want 1", err_cnt - e0);
    end
    vectors++;
    if (err_cyc !== e + LAT) begin
      errors++; $display("FAIL break err cycle: got %0d want %0d", err_cyc, e + LAT);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    vectors++;
    if (rdy_cnt !== r0 || err_cnt !== e0 + 1) begin
      errors++; $display("FAIL break after idle: got rdy %0d err %0d want 0 1", rdy_cnt - r0, err_cnt - e0);
    end
    check_good("after_break_0f", 8'h0F, 1'b0);
  endtask

  task automatic test_glitch;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    rx_i = 1'b0 ^ INV;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1 ^ INV;
    repeat (3 * CPB) @(negedge clk_i);
    vectors++;
    if (rdy_cnt !== r0 || err_cnt !== e0) begin
      errors++; $display("FAIL glitch pulses: got rdy %0d err %0d want 0 0", rdy_cnt - r0, err_cnt - e0);
    end
    check_good("after_glitch_a5", 8'hA5, 1'b0);
  endtask

  task automatic test_reset_mid_byte;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx_i = 1'b1 ^ INV;
    repeat (HALF) @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({data_o, rdy_o, err_o} !== 10'h000) begin
      errors++; $display("FAIL mid reset outputs: got %02h/%b/%b want 00/0/0", data_o, rdy_o, err_o);
    end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (20 * CPB) @(negedge clk_i);
    vectors++;
    if (rdy_cnt !== r0 || err_cnt !== e0) begin
      errors++; $display("FAIL mid reset pulses: got rdy %0d err %0d want 0 0", rdy_cnt - r0, err_cnt - e0);
    end
    vectors++;
    if (data_o !== 8'h00) begin
      errors++; $display("FAIL mid reset data: got %02h want 00", data_o);
    end
    exp_data = 8'h00;
    check_good("after_reset_3c", 8'h3C, 1'b0);
  endtask

  initial begin
    test_reset;
    test_valid;
    test_back_to_back;
    test_parity_error;
    test_break;
    test_glitch;
    test_reset_mid_byte;
    vectors++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL rdy_err_overlap: got %0d want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
